// File: rtl/led_panel_pkg.sv
// -----------------------------------------------------------------------------
// led_panel_pkg
// Shared definitions for the LED panel framebuffer write path:
//   - fb_state_t : write-controller FSM states
//   - ROW_W/COL_W/PIX_W/ADDR_W : default geometry of one framebuffer half
//   - FILL_WORDS : number of words a full-buffer fill writes
// No ports (package).
// -----------------------------------------------------------------------------
package led_panel_pkg;

    localparam int ROW_W      = 4;
    localparam int COL_W      = 5;
    localparam int PIX_W      = 24;
    localparam int ADDR_W     = 10;
    localparam int FILL_WORDS = 512;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_DRAIN      = 2'd1,
        ST_FLIP       = 2'd2,
        ST_WAIT_FRAME = 2'd3
    } fb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. On contention the requester that was not
// granted last wins; a lone requester is granted immediately. Grants are
// combinational, the last-grant record is registered.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_req0/1   : requests (0 = host, 1 = fill in this design)
//   o_gnt0/1   : one-hot (or zero) grants, same cycle as request
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    // 0 = requester 0 granted last, 1 = requester 1 granted last.
    // Resets to 1 so requester 0 wins the first contention.
    logic r_last;

    always_comb begin
        o_gnt0 = i_req0 & (~i_req1 | r_last);
        o_gnt1 = i_req1 & (~i_req0 | ~r_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (o_gnt0) begin
            r_last <= 1'b0;
        end else if (o_gnt1) begin
            r_last <= 1'b1;
        end
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// -----------------------------------------------------------------------------
// fb_write_ctrl
// Double-buffered framebuffer write controller. Host pixel writes and a
// whole-buffer fill engine share one memory write port through a round-robin
// arbiter; all writes target the back buffer (~actual_buffer). A swap request
// drains any running fill, toggles selected_buffer and then waits until the
// panel reports it is showing the new buffer at a frame start.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   h_req/h_addr/h_data, h_gnt  : host write request, combinational accept
//   fill_start/fill_color       : start a fill, colour sampled on accept
//   fill_busy                   : fill in progress
//   swap_req, swap_pending      : request buffer exchange / exchange in flight
//   swap_done                   : one-cycle pulse when the new buffer is shown
//   selected_buffer             : buffer requested of the panel scanner
//   actual_buffer, frame_start  : panel status (displayed buffer, row-0 flag)
//   wr_en/wr_we_hi/wr_we_lo     : registered memory write strobe + half enables
//   wr_addr/wr_data             : registered memory address / pixel
// -----------------------------------------------------------------------------
module fb_write_ctrl #(
    parameter int ROW_W = led_panel_pkg::ROW_W,
    parameter int COL_W = led_panel_pkg::COL_W,
    parameter int PIX_W = led_panel_pkg::PIX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   h_req,
    input  logic [ROW_W+COL_W:0]   h_addr,
    input  logic [PIX_W-1:0]       h_data,
    output logic                   h_gnt,
    input  logic                   fill_start,
    input  logic [PIX_W-1:0]       fill_color,
    output logic                   fill_busy,
    input  logic                   swap_req,
    output logic                   swap_pending,
    output logic                   swap_done,
    output logic                   selected_buffer,
    input  logic                   actual_buffer,
    input  logic                   frame_start,
    output logic                   wr_en,
    output logic                   wr_we_hi,
    output logic                   wr_we_lo,
    output logic [ROW_W+COL_W:0]   wr_addr,
    output logic [PIX_W-1:0]       wr_data
);

    import led_panel_pkg::*;

    localparam int CNT_W = ROW_W + COL_W;
    localparam int AW    = CNT_W + 1;

    fb_state_t        r_state;
    logic [CNT_W-1:0] r_fill_cnt;
    logic [PIX_W-1:0] r_fill_color;
    logic             r_fill_busy;
    logic             r_swap_pending;
    logic             r_swap_done;
    logic             r_sel;
    logic             r_fs_d;
    logic             r_wr_en;
    logic             r_we_hi;
    logic             r_we_lo;
    logic [AW-1:0]    r_wr_addr;
    logic [PIX_W-1:0] r_wr_data;

    logic w_back;
    logic w_host_req;
    logic w_fill_req;
    logic w_host_gnt;
    logic w_fill_gnt;
    logic w_fill_last;
    logic w_fill_acc;
    logic w_fs_rise;

    // Writes always land in the buffer the panel is not showing.
    assign w_back      = ~actual_buffer;
    // Host only competes in RUN; fill keeps its slot in DRAIN so it can finish.
    assign w_host_req  = ~rst & h_req & (r_state == ST_RUN);
    assign w_fill_req  = ~rst & r_fill_busy & ((r_state == ST_RUN) | (r_state == ST_DRAIN));
    assign w_fill_last = w_fill_gnt & (r_fill_cnt == '1);
    assign w_fill_acc  = fill_start & (r_state == ST_RUN) & ~r_fill_busy & ~r_swap_pending;
    assign w_fs_rise   = frame_start & ~r_fs_d;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_req0 (w_host_req),
        .i_req1 (w_fill_req),
        .o_gnt0 (w_host_gnt),
        .o_gnt1 (w_fill_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_fill_cnt     <= '0;
            r_fill_color   <= '0;
            r_fill_busy    <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_done    <= 1'b0;
            r_sel          <= 1'b0;
            r_fs_d         <= 1'b0;
            r_wr_en        <= 1'b0;
            r_we_hi        <= 1'b0;
            r_we_lo        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
        end else begin
            r_fs_d      <= frame_start;
            r_swap_done <= 1'b0;

            // Registered write port: grant in cycle N -> strobe in cycle N+1.
            r_wr_en <= w_host_gnt | w_fill_gnt;
            if (w_host_gnt) begin
                r_wr_addr <= {w_back, h_addr[CNT_W-1:0]};
                r_wr_data <= h_data;
                r_we_hi   <= ~h_addr[AW-1];
                r_we_lo   <= h_addr[AW-1];
            end else if (w_fill_gnt) begin
                r_wr_addr <= {w_back, r_fill_cnt};
                r_wr_data <= r_fill_color;
                r_we_hi   <= 1'b1;
                r_we_lo   <= 1'b1;
            end else begin
                r_we_hi   <= 1'b0;
                r_we_lo   <= 1'b0;
            end

            // Fill engine; the counter wraps back to 0 after the last word.
            if (w_fill_acc) begin
                r_fill_busy  <= 1'b1;
                r_fill_cnt   <= '0;
                r_fill_color <= fill_color;
            end else if (w_fill_gnt) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
                if (w_fill_last) begin
                    r_fill_busy <= 1'b0;
                end
            end

            case (r_state)
                ST_RUN: begin
                    if (swap_req) begin
                        r_swap_pending <= 1'b1;
                        // A fill accepted on the same edge must drain too.
                        r_state <= (r_fill_busy | w_fill_acc) ? ST_DRAIN : ST_FLIP;
                    end
                end
                ST_DRAIN: begin
                    if (w_fill_last | ~r_fill_busy) begin
                        r_state <= ST_FLIP;
                    end
                end
                ST_FLIP: begin
                    r_sel   <= ~r_sel;
                    r_state <= ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    // Only a frame start showing the requested buffer completes
                    // the swap; a mismatched one is ignored.
                    if (w_fs_rise && (actual_buffer == r_sel)) begin
                        r_swap_pending <= 1'b0;
                        r_swap_done    <= 1'b1;
                        r_state        <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign h_gnt           = w_host_gnt;
    assign fill_busy       = r_fill_busy;
    assign swap_pending    = r_swap_pending;
    assign swap_done       = r_swap_done;
    assign selected_buffer = r_sel;
    assign wr_en           = r_wr_en;
    assign wr_we_hi        = r_we_hi;
    assign wr_we_lo        = r_we_lo;
    assign wr_addr         = r_wr_addr;
    assign wr_data         = r_wr_data;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fb_write_ctrl
// Directed self-checking bench for fb_write_ctrl. Inputs are driven 1ns after
// the rising edge; registered outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_fb_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        h_req;
    logic [9:0]  h_addr;
    logic [23:0] h_data;
    logic        h_gnt;
    logic        fill_start;
    logic [23:0] fill_color;
    logic        fill_busy;
    logic        swap_req;
    logic        swap_pending;
    logic        swap_done;
    logic        selected_buffer;
    logic        actual_buffer;
    logic        frame_start;
    logic        wr_en;
    logic        wr_we_hi;
    logic        wr_we_lo;
    logic [9:0]  wr_addr;
    logic [23:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fb_write_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .h_req           (h_req),
        .h_addr          (h_addr),
        .h_data          (h_data),
        .h_gnt           (h_gnt),
        .fill_start      (fill_start),
        .fill_color      (fill_color),
        .fill_busy       (fill_busy),
        .swap_req        (swap_req),
        .swap_pending    (swap_pending),
        .swap_done       (swap_done),
        .selected_buffer (selected_buffer),
        .actual_buffer   (actual_buffer),
        .frame_start     (frame_start),
        .wr_en           (wr_en),
        .wr_we_hi        (wr_we_hi),
        .wr_we_lo        (wr_we_lo),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; h_req = 1'b0; h_addr = '0; h_data = '0;
        fill_start = 1'b0; fill_color = '0; swap_req = 1'b0;
        actual_buffer = 1'b0; frame_start = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        rst = 1'b1; h_req = 1'b1;
        tick; tick;
        n_checks++; if (h_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_h_gnt: got %b want 0", h_gnt); end
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_checks++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL reset_fill_busy: got %b want 0", fill_busy); end
        n_checks++; if (swap_pending !== 1'b0 || swap_done !== 1'b0) begin n_fail++; $display("FAIL reset_swap: got pend=%b done=%b want 0 0", swap_pending, swap_done); end
        n_checks++; if (selected_buffer !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0", selected_buffer); end
        n_checks++; if ({wr_we_hi, wr_we_lo, wr_addr, wr_data} !== 36'h0) begin n_fail++; $display("FAIL reset_wr_bus: got hi=%b lo=%b a=%h d=%h want zeros", wr_we_hi, wr_we_lo, wr_addr, wr_data); end
        h_req = 1'b0; rst = 1'b0;
        tick;
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_release_wr_en: got %b want 0", wr_en); end
    endtask

    task automatic test_host_write;
        do_reset;
        h_req = 1'b1; h_addr = 10'h3FF; h_data = 24'hABCDEF; actual_buffer = 1'b0;
        #1;
        n_checks++; if (h_gnt !== 1'b1) begin n_fail++; $display("FAIL host_gnt: got %b want 1", h_gnt); end
        tick;
        h_req = 1'b0;
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 10'h3FF || wr_data !== 24'hABCDEF) begin n_fail++; $display("FAIL host_lo_write: got en=%b a=%h d=%h want 1 3ff abcdef", wr_en, wr_addr, wr_data); end
        n_checks++; if (wr_we_lo !== 1'b1 || wr_we_hi !== 1'b0) begin n_fail++; $display("FAIL host_lo_enables: got hi=%b lo=%b want 0 1", wr_we_hi, wr_we_lo); end
        // Half 0 (hi memory), panel showing buffer 1 -> back buffer 0.
        h_req = 1'b1; h_addr = 10'h055; h_data = 24'h123456; actual_buffer = 1'b1;
        tick;
        h_req = 1'b0;
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 10'h055 || wr_data !== 24'h123456) begin n_fail++; $display("FAIL host_hi_write: got en=%b a=%h d=%h want 1 055 123456", wr_en, wr_addr, wr_data); end
        n_checks++; if (wr_we_hi !== 1'b1 || wr_we_lo !== 1'b0) begin n_fail++; $display("FAIL host_hi_enables: got hi=%b lo=%b want 1 0", wr_we_hi, wr_we_lo); end
        tick;
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL host_single_cycle: got %b want 0", wr_en); end
    endtask

    task automatic test_fill;
        int busy_cnt;
        int wr_cnt;
        logic [9:0] exp_addr;
        do_reset;
        fill_color = 24'h00FF00; fill_start = 1'b1;
        tick;
        fill_start = 1'b0;
        busy_cnt = 0; wr_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            // A second start while busy must be ignored.
            if (i == 50) begin fill_start = 1'b1; fill_color = 24'hFFFFFF; end
            else fill_start = 1'b0;
            if (fill_busy === 1'b1) busy_cnt++;
            if (wr_en === 1'b1) begin
                exp_addr = 10'h200 | 10'(wr_cnt);
                n_checks++;
                if (wr_addr !== exp_addr || wr_data !== 24'h00FF00 || wr_we_hi !== 1'b1 || wr_we_lo !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fill_word_%0d: got a=%h d=%h hi=%b lo=%b want a=%h d=00ff00 hi=1 lo=1", wr_cnt, wr_addr, wr_data, wr_we_hi, wr_we_lo, exp_addr);
                end
                wr_cnt++;
            end
            tick;
        end
        n_checks++; if (wr_cnt != 512) begin n_fail++; $display("FAIL fill_write_count: got %0d want 512", wr_cnt); end
        n_checks++; if (busy_cnt != 512) begin n_fail++; $display("FAIL fill_busy_cycles: got %0d want 512", busy_cnt); end
    endtask

    task automatic test_round_robin;
        int k;
        int fill_wr;
        logic exp_gnt;
        do_reset;
        fill_color = 24'h0000FF; fill_start = 1'b1;
        tick;
        fill_start = 1'b0;
        h_req = 1'b1; h_addr = 10'h001; h_data = 24'hAAAAAA;
        #1;
        k = 0; fill_wr = 0;
        while (k < 1100) begin
            if (wr_en === 1'b1 && wr_data === 24'h0000FF) fill_wr++;
            if (fill_busy !== 1'b1) break;
            exp_gnt = (k % 2 == 0);
            n_checks++;
            if (h_gnt !== exp_gnt) begin n_fail++; $display("FAIL rr_cycle_%0d: got h_gnt=%b want %b", k, h_gnt, exp_gnt); end
            tick;
            k++;
        end
        n_checks++; if (k != 1024) begin n_fail++; $display("FAIL rr_fill_duration: got %0d want 1024", k); end
        n_checks++; if (fill_wr != 512) begin n_fail++; $display("FAIL rr_fill_writes: got %0d want 512", fill_wr); end
        n_checks++; if (h_gnt !== 1'b1) begin n_fail++; $display("FAIL rr_host_after_fill: got %b want 1", h_gnt); end
        h_req = 1'b0;
    endtask

    task automatic test_swap_with_host;
        do_reset;
        h_req = 1'b1; h_addr = 10'h200; h_data = 24'h5A5A5A; swap_req = 1'b1;
        #1;
        n_checks++; if (h_gnt !== 1'b1) begin n_fail++; $display("FAIL swaphost_gnt: got %b want 1", h_gnt); end
        tick;
        swap_req = 1'b0;
        n_checks++; if (wr_en !== 1'b1 || wr_data !== 24'h5A5A5A) begin n_fail++; $display("FAIL swaphost_write: got en=%b d=%h want 1 5a5a5a", wr_en, wr_data); end
        n_checks++; if (swap_pending !== 1'b1 || h_gnt !== 1'b0) begin n_fail++; $display("FAIL swaphost_flip: got pend=%b gnt=%b want 1 0", swap_pending, h_gnt); end
        tick;
        n_checks++; if (selected_buffer !== 1'b1 || h_gnt !== 1'b0) begin n_fail++; $display("FAIL swaphost_sel: got sel=%b gnt=%b want 1 0", selected_buffer, h_gnt); end
        actual_buffer = 1'b1; frame_start = 1'b1;
        tick;
        n_checks++; if (swap_done !== 1'b1 || swap_pending !== 1'b0 || h_gnt !== 1'b1) begin n_fail++; $display("FAIL swaphost_done: got done=%b pend=%b gnt=%b want 1 0 1", swap_done, swap_pending, h_gnt); end
        tick;
        n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL swaphost_done_pulse: got %b want 0", swap_done); end
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 10'h000) begin n_fail++; $display("FAIL swaphost_new_back: got en=%b a=%h want 1 000", wr_en, wr_addr); end
        frame_start = 1'b0; h_req = 1'b0;
    endtask

    task automatic test_swap_drain;
        int k;
        do_reset;
        fill_color = 24'h123456; fill_start = 1'b1;
        tick;
        fill_start = 1'b0;
        h_req = 1'b1; h_addr = 10'h000; h_data = 24'h777777;
        repeat (100) tick;
        swap_req = 1'b1;
        tick;
        swap_req = 1'b0;
        n_checks++; if (swap_pending !== 1'b1 || fill_busy !== 1'b1) begin n_fail++; $display("FAIL drain_enter: got pend=%b busy=%b want 1 1", swap_pending, fill_busy); end
        k = 0;
        while (k < 700 && selected_buffer !== 1'b1) begin
            swap_req = (k == 10);
            n_checks++;
            if (h_gnt !== 1'b0) begin n_fail++; $display("FAIL drain_h_gnt_%0d: got %b want 0", k, h_gnt); end
            tick;
            k++;
        end
        swap_req = 1'b0;
        n_checks++; if (selected_buffer !== 1'b1 || fill_busy !== 1'b0) begin n_fail++; $display("FAIL drain_flip: got sel=%b busy=%b want 1 0", selected_buffer, fill_busy); end
        repeat (5) tick;
        n_checks++; if (swap_done !== 1'b0 || swap_pending !== 1'b1 || h_gnt !== 1'b0) begin n_fail++; $display("FAIL wait_hold: got done=%b pend=%b gnt=%b want 0 1 0", swap_done, swap_pending, h_gnt); end
        // Frame start with the wrong buffer displayed: no completion.
        frame_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) frame_start = 1'b0;
            tick;
            n_checks++;
            if (swap_done !== 1'b0 || swap_pending !== 1'b1) begin n_fail++; $display("FAIL wait_mismatch_%0d: got done=%b pend=%b want 0 1", i, swap_done, swap_pending); end
        end
        actual_buffer = 1'b1; frame_start = 1'b1;
        tick;
        n_checks++; if (swap_done !== 1'b1 || swap_pending !== 1'b0) begin n_fail++; $display("FAIL wait_match_done: got done=%b pend=%b want 1 0", swap_done, swap_pending); end
        tick;
        n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL wait_done_pulse: got %b want 0", swap_done); end
        frame_start = 1'b0; h_req = 1'b0;
    endtask

    task automatic test_reset_midfill;
        int wr_cnt;
        do_reset;
        fill_color = 24'hC0FFEE; fill_start = 1'b1;
        tick;
        fill_start = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (wr_en === 1'b1) wr_cnt++;
            if (wr_cnt == 200) break;
            tick;
        end
        n_checks++; if (wr_cnt != 200) begin n_fail++; $display("FAIL midfill_reach: got %0d want 200", wr_cnt); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        n_checks++; if (wr_en !== 1'b0 || fill_busy !== 1'b0 || selected_buffer !== 1'b0) begin n_fail++; $display("FAIL midfill_release: got en=%b busy=%b sel=%b want 0 0 0", wr_en, fill_busy, selected_buffer); end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if (wr_en !== 1'b0) begin n_fail++; $display("FAIL midfill_quiet_%0d: got %b want 0", i, wr_en); end
        end
        // Abort a swap while waiting for the frame.
        swap_req = 1'b1;
        tick;
        swap_req = 1'b0;
        tick;
        n_checks++; if (selected_buffer !== 1'b1 || swap_pending !== 1'b1) begin n_fail++; $display("FAIL midswap_setup: got sel=%b pend=%b want 1 1", selected_buffer, swap_pending); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        n_checks++; if (selected_buffer !== 1'b0 || swap_pending !== 1'b0) begin n_fail++; $display("FAIL midswap_abort: got sel=%b pend=%b want 0 0", selected_buffer, swap_pending); end
    endtask

    initial begin
        test_reset;
        test_host_write;
        test_fill;
        test_round_robin;
        test_swap_with_host;
        test_swap_drain;
        test_reset_midfill;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_write_ctrl.md
FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 Parameter ROW_W, default 4, row address bits.
REQ-002 Parameter COL_W, default 5, column address bits.
REQ-003 Parameter PIX_W, default 24, pixel width {B[23:16],G[15:8],R[7:0]}.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 h_req  in  1  host write request.
REQ-007 h_addr  in  10  {half, row[3:0], col[4:0]}; half 0 = hi memory, 1 = lo memory.
REQ-008 h_data  in  24  host pixel.
REQ-009 h_gnt  out  1  host write accepted this cycle (combinational).
REQ-010 fill_start  in  1  pulse; fill whole back buffer with fill_color.
REQ-011 fill_color  in  24  fill pixel, sampled on accepted fill_start.
REQ-012 fill_busy  out  1  fill in progress.
REQ-013 swap_req  in  1  pulse; request front/back exchange.
REQ-014 swap_pending  out  1  swap requested, not yet visible.
REQ-015 swap_done  out  1  one-cycle pulse; new buffer now displayed.
REQ-016 selected_buffer  out  1  buffer requested of panel scanner.
REQ-017 actual_buffer  in  1  buffer panel is displaying.
REQ-018 frame_start  in  1  panel frame flag (level, high during row 0).
REQ-019 wr_en / wr_we_hi / wr_we_lo  out  1 each  memory write strobe and half enables.
REQ-020 wr_addr  out  10  {back_buffer, row[3:0], col[4:0]}; wr_data  out  24.

Function
REQ-021 FSM states RUN, DRAIN, FLIP, WAIT_FRAME.
REQ-022 back_buffer SHALL equal ~actual_buffer; writes only in RUN or DRAIN.
REQ-023 RUN: host and fill contend via 2-way round-robin; on contention grant the requester not granted last; uncontended requester granted immediately.
REQ-024 Write latency: grant at cycle N -> wr_en, wr_addr, wr_data, enables registered and valid cycle N+1, single cycle.
REQ-025 Host write: wr_we_hi = ~h_addr[9], wr_we_lo = h_addr[9].
REQ-026 Fill: fill_start accepted only in RUN with fill_busy=0 and swap_pending=0; otherwise ignored.
REQ-027 Fill: 9-bit counter {row,col} 0..511, one word per fill grant, wr_we_hi=wr_we_lo=1, wr_data = latched fill_color.
REQ-028 fill_busy rises the cycle after accepted fill_start, falls the cycle after the grant for word 511.
REQ-029 swap_req in RUN: swap_pending=1 next cycle; -> DRAIN if fill_busy, else -> FLIP.
REQ-030 swap_req while swap_pending=1 ignored.
REQ-031 swap_req and h_req in same cycle: host write granted, swap latched that edge.
REQ-032 DRAIN: h_gnt=0; fill granted every cycle until done, then -> FLIP.
REQ-033 FLIP: toggle selected_buffer, h_gnt=0, one cycle, -> WAIT_FRAME.
REQ-034 WAIT_FRAME: h_gnt=0; on rising edge of frame_start (registered fs_d) with actual_buffer==selected_buffer -> RUN, swap_pending=0 and swap_done=1 next cycle.
REQ-035 Rising frame_start with actual_buffer mismatch ignored; keep waiting, no timeout.

Reset
REQ-036 On rst: state RUN, all outputs 0, selected_buffer 0, fill counter 0, fs_d 0, round-robin last = fill (host wins first contention).
REQ-037 rst mid-fill or mid-swap aborts; no wr_en the cycle after rst deasserts.

Structure
REQ-038 Shared package led_panel_pkg: state enum, ROW_W, COL_W, PIX_W, ADDR_W=10, FILL_WORDS=512.
REQ-039 One sub-module rr_arb2 (2-requester round-robin, last-grant register); rest flat.

Verification
REQ-040 Host write h_addr=10'h3FF, h_data=24'hABCDEF, actual_buffer=0 -> next cycle wr_addr=10'h3FF, wr_we_lo=1, wr_we_hi=0, data ABCDEF.
REQ-041 fill_start, color 24'h00FF00, no host -> exactly 512 wr_en, addresses {1,0..511}, both enables, fill_busy high 512 cycles.
REQ-042 Host h_req held during fill -> grants alternate host/fill, host first; fill completes after 1024 cycles.
REQ-043 swap_req mid-fill, h_req held -> h_gnt=0, fill finishes, selected_buffer toggles 0->1, swap_done only after frame_start rises with actual_buffer=1.
REQ-044 frame_start rise with actual_buffer=0 in WAIT_FRAME -> no swap_done; second rise with actual_buffer=1 -> swap_done one cycle.
REQ-045 rst at fill word 200 -> fill_busy=0, no wr_en after release, selected_buffer=0.
